// File: rtl/conv_stream_dispatch.sv
// Stream dispatcher: routes one AXI-stream input to a selected consumer lane for a
// programmed number of beats, and delays per-lane start requests by START_DELAY cycles.
module conv_stream_dispatch #(
    parameter int DATA_WIDTH  = 128,
    parameter int NUM_DEST    = 2,
    parameter int DEST_W      = 1,
    parameter int START_DELAY = 4,
    parameter int BEAT_CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     Control,
    input  logic [BEAT_CNT_W-1:0]          Beat_Num,
    input  logic [NUM_DEST-1:0]            Sign,
    output logic [NUM_DEST-1:0]            Start,
    input  logic [DATA_WIDTH-1:0]          S_Data,
    input  logic                           S_Valid,
    output logic                           S_Ready,
    output logic [NUM_DEST*DATA_WIDTH-1:0] M_Data,
    output logic [NUM_DEST-1:0]            M_Valid,
    input  logic [NUM_DEST-1:0]            M_Ready,
    output logic                           Busy,
    output logic [DEST_W-1:0]              Cur_Dest,
    output logic [BEAT_CNT_W-1:0]          Beat_Cnt,
    output logic                           Done,
    output logic                           Sel_Err
);

    typedef enum logic {IDLE, ROUTE} state_t;

    localparam logic [3:0]            CTL_ABORT = 4'hF;
    localparam logic [3:0]            CTL_MAX   = 4'(NUM_DEST);
    localparam logic [BEAT_CNT_W-1:0] ONE       = {{(BEAT_CNT_W-1){1'b0}}, 1'b1};

    state_t                state, state_next;
    logic [BEAT_CNT_W-1:0] beat_num_q;
    logic                  is_select, is_abort, accept, last_beat;
    logic                  load, done_next, sel_err_next;

    assign is_select = (Control != 4'd0) && (Control <= CTL_MAX);
    assign is_abort  = (Control == CTL_ABORT);
    // Acceptance is taken from M_Ready directly so it does not loop through S_Ready.
    assign accept    = (state == ROUTE) && S_Valid && M_Ready[Cur_Dest];
    assign last_beat = accept && (Beat_Cnt == beat_num_q - ONE);

    assign Busy   = (state == ROUTE);
    assign M_Data = {NUM_DEST{S_Data}};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next   = state;
        load         = 1'b0;
        done_next    = 1'b0;
        sel_err_next = 1'b0;
        S_Ready      = 1'b0;
        M_Valid      = '0;
        case (state)
            IDLE: begin
                if (is_select) begin
                    load = 1'b1;
                    if (Beat_Num == '0) done_next  = 1'b1;
                    else                state_next = ROUTE;
                end
            end
            ROUTE: begin
                S_Ready           = M_Ready[Cur_Dest];
                M_Valid[Cur_Dest] = S_Valid;
                sel_err_next      = is_select;
                if (is_abort) begin
                    state_next = IDLE;
                end else if (last_beat) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            Cur_Dest   <= '0;
            beat_num_q <= '0;
            Beat_Cnt   <= '0;
            Done       <= 1'b0;
            Sel_Err    <= 1'b0;
        end else begin
            state   <= state_next;
            Done    <= done_next;
            Sel_Err <= sel_err_next;
            if (load) begin
                Cur_Dest   <= DEST_W'(Control - 4'd1);
                beat_num_q <= Beat_Num;
                Beat_Cnt   <= '0;
            end else if (accept) begin
                Beat_Cnt <= Beat_Cnt + ONE;
            end
        end
    end

    generate
        if (START_DELAY == 0) begin : g_no_delay
            assign Start = Sign;
        end else begin : g_delay
            logic [NUM_DEST-1:0] stage [START_DELAY];
            // NOTE: these stages are plain flops, not RAM, so they are cleared on reset like any state.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < START_DELAY; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= Sign;
                    for (int i = 1; i < START_DELAY; i++) stage[i] <= stage[i-1];
                end
            end
            assign Start = stage[START_DELAY-1];
        end
    endgenerate

endmodule
